// File: rtl/vga_pkg.sv
// Shared timing constants, framebuffer geometry and colour type for the VGA scanout.
// Optional build macro used by vga_scanout: SCANOUT_TEST_PATTERN_EN.
package vga_pkg;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;   // 800
    localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;   // 525
    localparam int H_SYNC_START = H_VIS + H_FP;                   // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;          // 752
    localparam int V_SYNC_START = V_VIS + V_FP;                   // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;          // 492

    localparam int FB_W   = 160;
    localparam int FB_H   = 120;
    localparam int ADDR_W = 15;
    localparam int CNT_W  = 10;
    localparam int DAC_W  = 10;

    typedef logic [2:0] colour_t;

    // y*160 + x as two shifts and adds: 160 = 128 + 32.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] fy, input logic [7:0] fx);
        fb_addr = {fy, 7'b000_0000} + {2'b00, fy, 5'b0_0000} + {7'b000_0000, fx};
    endfunction

    // One colour bit drives a full-scale or zero DAC code.
    function automatic logic [DAC_W-1:0] dac_expand(input logic b);
        dac_expand = {DAC_W{b}};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider plus horizontal/vertical scan counters, raw sync and
// visible-area decode, and the once-per-frame update strobe.
module vga_timing_gen #(
    parameter int H_VIS  = vga_pkg::H_VIS,
    parameter int H_FP   = vga_pkg::H_FP,
    parameter int H_SYNC = vga_pkg::H_SYNC,
    parameter int H_BP   = vga_pkg::H_BP,
    parameter int V_VIS  = vga_pkg::V_VIS,
    parameter int V_FP   = vga_pkg::V_FP,
    parameter int V_SYNC = vga_pkg::V_SYNC,
    parameter int V_BP   = vga_pkg::V_BP
) (
    input  logic                       clk,
    input  logic                       resetn,
    output logic                       pix_en_o,
    output logic [vga_pkg::CNT_W-1:0]  h_cnt_o,
    output logic [vga_pkg::CNT_W-1:0]  v_cnt_o,
    output logic                       hs_o,
    output logic                       vs_o,
    output logic                       visible_o,
    output logic                       frame_done_o
);
    import vga_pkg::*;

    localparam logic [CNT_W-1:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [CNT_W-1:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_FD_ROW = 10'(V_VIS - 1);

    logic             pix_en_q, pix_en_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             frame_done_q, frame_done_d;

    // Next-state: divide clk by two, advance the scan on pixel ticks, flag entry into vblank.
    always_comb begin
        pix_en_d     = ~pix_en_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        frame_done_d = 1'b0;
        if (pix_en_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d      = 10'd0;
                frame_done_d = (v_cnt_q == V_FD_ROW);
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 10'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end else begin
            frame_done_d = 1'b0;
        end
    end

    // State registers; pix_en is 0 through reset so the first clk after release is not a tick.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_en_q     <= 1'b0;
            h_cnt_q      <= 10'd0;
            v_cnt_q      <= 10'd0;
            frame_done_q <= 1'b0;
        end else begin
            pix_en_q     <= pix_en_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_en_o     = pix_en_q;
    assign h_cnt_o      = h_cnt_q;
    assign v_cnt_o      = v_cnt_q;
    assign hs_o         = ~((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    assign vs_o         = ~((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    assign visible_o    = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    assign frame_done_o = frame_done_q;

endmodule

// File: rtl/vga_scanout.sv
// 160x120 framebuffer scanout to 640x480@60 VGA with 4x4 pixel upscaling.
// Build macro SCANOUT_TEST_PATTERN_EN: replace framebuffer colour with five
// 128-pixel vertical bars (bar k has colour k); rd_addr still scans normally.
module vga_scanout #(
    parameter int H_VIS  = vga_pkg::H_VIS,
    parameter int H_FP   = vga_pkg::H_FP,
    parameter int H_SYNC = vga_pkg::H_SYNC,
    parameter int H_BP   = vga_pkg::H_BP,
    parameter int V_VIS  = vga_pkg::V_VIS,
    parameter int V_FP   = vga_pkg::V_FP,
    parameter int V_SYNC = vga_pkg::V_SYNC,
    parameter int V_BP   = vga_pkg::V_BP
) (
    input  logic                        clk,
    input  logic                        resetn,
    output logic [vga_pkg::ADDR_W-1:0]  rd_addr,
    input  logic [2:0]                  rd_data,
    output logic                        frame_done,
    output logic                        VGA_CLK,
    output logic                        VGA_HS,
    output logic                        VGA_VS,
    output logic                        VGA_BLANK_N,
    output logic                        VGA_SYNC_N,
    output logic [vga_pkg::DAC_W-1:0]   VGA_R,
    output logic [vga_pkg::DAC_W-1:0]   VGA_G,
    output logic [vga_pkg::DAC_W-1:0]   VGA_B
);
    import vga_pkg::*;

    logic             pix_en_s;
    logic [CNT_W-1:0] h_cnt_s, v_cnt_s;
    logic             hs_raw_s, vs_raw_s, vis_raw_s;
    colour_t          colour_s;
    logic             unused_s;

    // Stage 1 holds the scan position's sync/visible while the RAM read is in flight.
    logic             hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    // Output stage drives the DAC pins.
    logic             hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d, vga_clk_q, vga_clk_d;
    logic [DAC_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    vga_timing_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk          (clk),
        .resetn       (resetn),
        .pix_en_o     (pix_en_s),
        .h_cnt_o      (h_cnt_s),
        .v_cnt_o      (v_cnt_s),
        .hs_o         (hs_raw_s),
        .vs_o         (vs_raw_s),
        .visible_o    (vis_raw_s),
        .frame_done_o (frame_done)
    );

`ifdef SCANOUT_TEST_PATTERN_EN
    colour_t pat1_q, pat1_d;
    assign colour_s = pat1_q;
    assign unused_s = ^{h_cnt_s[1:0], v_cnt_s[1:0], rd_data};
`else
    assign colour_s = rd_data;
    assign unused_s = ^{h_cnt_s[1:0], v_cnt_s[1:0]};
`endif

    // Next-state for the read pipeline and pins; everything moves only on pixel ticks.
    always_comb begin
        hs1_d     = hs1_q;
        vs1_d     = vs1_q;
        vis1_d    = vis1_q;
        rd_addr_d = rd_addr_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        vga_clk_d = ~pix_en_s;
`ifdef SCANOUT_TEST_PATTERN_EN
        pat1_d    = pat1_q;
`endif
        if (pix_en_s) begin
            hs1_d  = hs_raw_s;
            vs1_d  = vs_raw_s;
            vis1_d = vis_raw_s;
`ifdef SCANOUT_TEST_PATTERN_EN
            pat1_d = h_cnt_s[9:7];
`endif
            // Address only advances in the visible area; it holds through blanking.
            if (vis_raw_s) begin
                rd_addr_d = fb_addr(v_cnt_s[9:2], h_cnt_s[9:2]);
            end else begin
                rd_addr_d = rd_addr_q;
            end
            hs_d      = hs1_q;
            vs_d      = vs1_q;
            blank_n_d = vis1_q;
            // RAM data for the stage-1 address is stable by this tick.
            if (vis1_q) begin
                r_d = dac_expand(colour_s[2]);
                g_d = dac_expand(colour_s[1]);
                b_d = dac_expand(colour_s[0]);
            end else begin
                r_d = 10'd0;
                g_d = 10'd0;
                b_d = 10'd0;
            end
        end else begin
            hs_d = hs_q;
        end
    end

    // Pipeline and output registers with asynchronous reset to idle-screen values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            vis1_q    <= 1'b0;
            rd_addr_q <= 15'd0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= 10'd0;
            g_q       <= 10'd0;
            b_q       <= 10'd0;
            vga_clk_q <= 1'b0;
`ifdef SCANOUT_TEST_PATTERN_EN
            pat1_q    <= 3'd0;
`endif
        end else begin
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            vis1_q    <= vis1_d;
            rd_addr_q <= rd_addr_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            vga_clk_q <= vga_clk_d;
`ifdef SCANOUT_TEST_PATTERN_EN
            pat1_q    <= pat1_d;
`endif
        end
    end

    assign rd_addr     = rd_addr_q;
    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;

endmodule
